// File: rtl/calc_scheduler.sv
// calc_scheduler: two-requester front end sharing one 8-bit multiplier and
// one 8-bit divider. Grants one operation at a time, holds the latched
// operands on the units for EXEC_CYCLES cycles, then captures the result
// into the granted requester's response buffer.

module multiplier_8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic [7:0]  c,
  input  logic [7:0]  d,
  output logic [15:0] p
);
  // 0xFF*0xFF + 0xFF + 0xFF == 0xFFFF, so 16 bits hold every result exactly.
  assign p = ({8'h00, a} * {8'h00, b}) + {8'h00, c} + {8'h00, d};
endmodule

module divider_8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] q,
  output logic [7:0] r
);
  // Zero divisor yields zeros here; the scheduler substitutes its own result.
  assign q = (b == 8'h00) ? 8'h00 : a / b;
  assign r = (b == 8'h00) ? 8'h00 : a % b;
endmodule

module calc_scheduler #(
  parameter int EXEC_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic       req0_op,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic [7:0] req0_c,
  input  logic [7:0] req0_d,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic       req1_op,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  input  logic [7:0] req1_c,
  input  logic [7:0] req1_d,
  output logic       rsp0_valid,
  input  logic       rsp0_ready,
  output logic [7:0] rsp0_hi,
  output logic [7:0] rsp0_lo,
  output logic       rsp0_err,
  output logic       rsp1_valid,
  input  logic       rsp1_ready,
  output logic [7:0] rsp1_hi,
  output logic [7:0] rsp1_lo,
  output logic       rsp1_err,
  output logic       busy
);

  typedef enum logic {IDLE, EXEC} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic        prio_q;     // requester that wins when both are eligible
  logic        id_q;
  logic        op_q;
  logic [7:0]  a_q, b_q, c_q, d_q;

  logic        elig0, elig1, grant_valid, grant_id, accept;
  logic [15:0] mul_p;
  logic [7:0]  div_q, div_r;
  logic [7:0]  res_hi, res_lo;
  logic        res_err;
  logic        done;

  multiplier_8 u_mul (.a(a_q), .b(b_q), .c(c_q), .d(d_q), .p(mul_p));
  divider_8    u_div (.a(a_q), .b(b_q), .q(div_q), .r(div_r));

  // Arbitration: eligible requesters, round-robin tie-break, combinational ready.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    elig0       = req0_valid && !rsp0_valid;
    elig1       = req1_valid && !rsp1_valid;
    grant_valid = elig0 || elig1;
    grant_id    = (elig0 && elig1) ? prio_q : elig1;
    if (state_q == IDLE && !rst && grant_valid) begin
      req0_ready = !grant_id;
      req1_ready = grant_id;
    end
  end

  assign accept = req0_ready || req1_ready;
  assign done   = (state_q == EXEC) && (cnt_q == 4'd0);
  assign busy   = (state_q == EXEC);

  // Next-state logic for the IDLE/EXEC controller.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    if (cnt_q == 4'd0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Result selection from the shared units, with divide-by-zero override.
  always_comb begin
    res_hi  = mul_p[15:8];
    res_lo  = mul_p[7:0];
    res_err = 1'b0;
    if (op_q) begin
      if (b_q == 8'h00) begin
        res_hi  = 8'hFF;
        res_lo  = a_q;
        res_err = 1'b1;
      end else begin
        res_hi  = div_q;
        res_lo  = div_r;
      end
    end
  end

  // Control: counter, round-robin pointer and granted id.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= 4'd0;
      prio_q <= 1'b0;
      id_q   <= 1'b0;
    end else if (accept) begin
      cnt_q  <= CNT_LOAD;
      prio_q <= !grant_id;
      id_q   <= grant_id;
    end else if (state_q == EXEC && cnt_q != 4'd0) begin
      cnt_q  <= cnt_q - 4'd1;
    end
  end

  // Operand latch on accept; a change while not ready has no effect.
  always_ff @(posedge clk) begin
    // NOTE: operand registers are pure data qualified by state, so they carry no reset.
    if (accept) begin
      op_q <= grant_id ? req1_op : req0_op;
      a_q  <= grant_id ? req1_a  : req0_a;
      b_q  <= grant_id ? req1_b  : req0_b;
      c_q  <= grant_id ? req1_c  : req0_c;
      d_q  <= grant_id ? req1_d  : req0_d;
    end
  end

  // Response buffer 0: fill on completion, drain on handshake, data holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp0_valid <= 1'b0;
      rsp0_hi    <= 8'h00;
      rsp0_lo    <= 8'h00;
      rsp0_err   <= 1'b0;
    end else if (done && !id_q && !rsp0_valid) begin
      rsp0_valid <= 1'b1;
      rsp0_hi    <= res_hi;
      rsp0_lo    <= res_lo;
      rsp0_err   <= res_err;
    end else if (rsp0_valid && rsp0_ready) begin
      rsp0_valid <= 1'b0;
    end
  end

  // Response buffer 1: same behaviour as buffer 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp1_valid <= 1'b0;
      rsp1_hi    <= 8'h00;
      rsp1_lo    <= 8'h00;
      rsp1_err   <= 1'b0;
    end else if (done && id_q && !rsp1_valid) begin
      rsp1_valid <= 1'b1;
      rsp1_hi    <= res_hi;
      rsp1_lo    <= res_lo;
      rsp1_err   <= res_err;
    end else if (rsp1_valid && rsp1_ready) begin
      rsp1_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_calc_scheduler.sv
// Directed bench for calc_scheduler: one instance with EXEC_CYCLES=1 for
// function/arbitration/backpressure/reset, one with EXEC_CYCLES=3 for latency.

module tb_calc_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_op, req1_valid, req1_op;
  logic [7:0] req0_a, req0_b, req0_c, req0_d;
  logic [7:0] req1_a, req1_b, req1_c, req1_d;
  logic       rsp0_ready, rsp1_ready;

  logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, busy;
  logic [7:0] rsp0_hi, rsp0_lo, rsp1_hi, rsp1_lo;

  logic       x_req0_ready, x_req1_ready, x_rsp0_valid, x_rsp1_valid, x_rsp0_err, x_rsp1_err, x_busy;
  logic [7:0] x_rsp0_hi, x_rsp0_lo, x_rsp1_hi, x_rsp1_lo;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  calc_scheduler #(.EXEC_CYCLES(1)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_c(req0_c), .req0_d(req0_d),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_c(req1_c), .req1_d(req1_d),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_hi(rsp0_hi),
    .rsp0_lo(rsp0_lo), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_hi(rsp1_hi),
    .rsp1_lo(rsp1_lo), .rsp1_err(rsp1_err),
    .busy(busy)
  );

  calc_scheduler #(.EXEC_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(x_req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_c(req0_c), .req0_d(req0_d),
    .req1_valid(req1_valid), .req1_ready(x_req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_c(req1_c), .req1_d(req1_d),
    .rsp0_valid(x_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_hi(x_rsp0_hi),
    .rsp0_lo(x_rsp0_lo), .rsp0_err(x_rsp0_err),
    .rsp1_valid(x_rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_hi(x_rsp1_hi),
    .rsp1_lo(x_rsp1_lo), .rsp1_err(x_rsp1_err),
    .busy(x_busy)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req0(input logic op, input logic [7:0] a, b, c, d);
    req0_op = op; req0_a = a; req0_b = b; req0_c = c; req0_d = d;
  endtask

  task automatic set_req1(input logic op, input logic [7:0] a, b, c, d);
    req1_op = op; req1_a = a; req1_b = b; req1_c = c; req1_d = d;
  endtask

  task automatic do_reset();
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0]  ra, rb, rc, rd;
    logic        rop;
    logic [15:0] expv;
    logic        exp_err;
    int          served;

    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    set_req0(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    set_req1(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    tick(); tick();

    // Reset state, and ready suppressed while reset is high.
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("rst_ready0", {15'd0, req0_ready}, 16'd0);
    check("rst_ready1", {15'd0, req1_ready}, 16'd0);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_rsp_valid", {14'd0, rsp0_valid, rsp1_valid}, 16'd0);
    check("rst_rsp0_data", {rsp0_hi, rsp0_lo}, 16'h0000);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;
    tick();

    // Multiply corner: 0xFF*0xFF + 0xFF + 0xFF = 0xFFFF.
    set_req0(1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    req0_valid = 1'b1;
    #1;
    check("mul_ready0", {15'd0, req0_ready}, 16'd1);
    check("mul_ready1", {15'd0, req1_ready}, 16'd0);
    tick();
    req0_valid = 1'b0;
    set_req0(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    #1;
    check("mul_busy", {15'd0, busy}, 16'd1);
    check("mul_exec_ready", {15'd0, req0_ready}, 16'd0);
    check("mul_not_yet", {15'd0, rsp0_valid}, 16'd0);
    tick();
    check("mul_valid", {15'd0, rsp0_valid}, 16'd1);
    check("mul_data", {rsp0_hi, rsp0_lo}, 16'hFFFF);
    check("mul_err", {15'd0, rsp0_err}, 16'd0);
    check("mul_idle", {15'd0, busy}, 16'd0);
    rsp0_ready = 1'b1;
    tick();
    rsp0_ready = 1'b0;
    check("drain_valid", {15'd0, rsp0_valid}, 16'd0);
    check("drain_hold", {rsp0_hi, rsp0_lo}, 16'hFFFF);

    // Divide: 200 / 7 = 28 rem 4.
    set_req1(1'b1, 8'd200, 8'd7, 8'h33, 8'h44);
    req1_valid = 1'b1;
    #1;
    check("div_ready1", {15'd0, req1_ready}, 16'd1);
    tick();
    req1_valid = 1'b0;
    tick();
    check("div_valid", {15'd0, rsp1_valid}, 16'd1);
    check("div_data", {rsp1_hi, rsp1_lo}, {8'd28, 8'd4});
    check("div_err", {15'd0, rsp1_err}, 16'd0);
    rsp1_ready = 1'b1; tick(); rsp1_ready = 1'b0;

    // Divide by zero: hi=0xFF, lo=a, err=1.
    set_req0(1'b1, 8'h5A, 8'h00, 8'h00, 8'h00);
    req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    tick();
    check("dz_valid", {15'd0, rsp0_valid}, 16'd1);
    check("dz_data", {rsp0_hi, rsp0_lo}, 16'hFF5A);
    check("dz_err", {15'd0, rsp0_err}, 16'd1);
    rsp0_ready = 1'b1; tick(); rsp0_ready = 1'b0;

    // Plain multiply with addends: 0x12*0x34 + 1 + 2 = 0x03AB.
    set_req1(1'b0, 8'h12, 8'h34, 8'h01, 8'h02);
    req1_valid = 1'b1;
    tick();
    req1_valid = 1'b0;
    tick();
    check("mul2_data", {rsp1_hi, rsp1_lo}, 16'h03AB);
    rsp1_ready = 1'b1; tick(); rsp1_ready = 1'b0;

    // Arbitration from reset with both requesters valid and sinks ready.
    do_reset();
    check("arb_rst_clear", {rsp0_hi, rsp0_lo}, 16'h0000);
    set_req0(1'b0, 8'd3, 8'd4, 8'd0, 8'd0);
    set_req1(1'b1, 8'd9, 8'd2, 8'd0, 8'd0);
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("arb_g1", {14'd0, req0_ready, req1_ready}, 16'b10);
    tick();
    check("arb_exec1", {14'd0, req0_ready, req1_ready}, 16'b00);
    tick();
    check("arb_r0_data", {rsp0_hi, rsp0_lo}, 16'h000C);
    check("arb_g2", {14'd0, req0_ready, req1_ready}, 16'b01);
    tick();
    check("arb_exec2", {14'd0, req0_ready, req1_ready}, 16'b00);
    tick();
    check("arb_r1_data", {rsp1_hi, rsp1_lo}, {8'd4, 8'd1});
    check("arb_g3", {14'd0, req0_ready, req1_ready}, 16'b10);
    tick();
    tick();
    check("arb_g4", {14'd0, req0_ready, req1_ready}, 16'b01);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick(); tick();
    // Last grant was req0 and both buffers are empty: req1 must win the tie.
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("arb_rr_tie", {14'd0, req0_ready, req1_ready}, 16'b01);

    // Backpressure: rsp0 held full, req1 keeps being served.
    do_reset();
    rsp0_ready = 1'b0; rsp1_ready = 1'b1;
    set_req0(1'b0, 8'd2, 8'd3, 8'd0, 8'd0);
    set_req1(1'b1, 8'd100, 8'd10, 8'd0, 8'd0);
    req0_valid = 1'b1;
    tick();
    tick();
    check("bp_fill", {rsp0_hi, rsp0_lo}, 16'h0006);
    req1_valid = 1'b1;
    served = 0;
    for (int svc = 0; svc < 3; svc++) begin
      for (int w = 0; w < 6 && !req1_ready; w++) tick();
      check("bp_req1_served", {15'd0, req1_ready}, 16'd1);
      check("bp_req0_blocked", {15'd0, req0_ready}, 16'd0);
      check("bp_rsp0_stable", {7'd0, rsp0_valid, rsp0_lo}, {7'd0, 1'b1, 8'h06});
      if (req1_ready) served++;
      tick();
    end
    check("bp_served_count", 16'(served), 16'd3);
    for (int w = 0; w < 6 && !rsp1_valid; w++) tick();
    check("bp_rsp1_data", {rsp1_hi, rsp1_lo}, {8'd10, 8'd0});

    // Reset during EXEC discards the operation.
    do_reset();
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    set_req0(1'b0, 8'd1, 8'd1, 8'd0, 8'd0);
    req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    check("abort_busy", {15'd0, busy}, 16'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_idle", {15'd0, busy}, 16'd0);
    tick(); tick();
    check("abort_no_rsp", {14'd0, rsp0_valid, rsp1_valid}, 16'd0);
    check("abort_no_rsp3", {14'd0, x_rsp0_valid, x_rsp1_valid}, 16'd0);

    // EXEC_CYCLES=3 latency: accept at k, valid after edge k+3.
    do_reset();
    set_req0(1'b0, 8'd5, 8'd6, 8'd0, 8'd0);
    req0_valid = 1'b1;
    #1;
    check("lat3_ready", {15'd0, x_req0_ready}, 16'd1);
    tick();
    req0_valid = 1'b0;
    check("lat3_busy", {15'd0, x_busy}, 16'd1);
    tick();
    check("lat3_k1", {15'd0, x_rsp0_valid}, 16'd0);
    tick();
    check("lat3_k2", {14'd0, x_rsp0_valid, x_busy}, 16'b01);
    tick();
    check("lat3_k3", {14'd0, x_rsp0_valid, x_busy}, 16'b10);
    check("lat3_data", {x_rsp0_hi, x_rsp0_lo}, 16'h001E);
    rsp0_ready = 1'b1; tick(); rsp0_ready = 1'b0;

    // Random operations through req0 against an arithmetic model.
    do_reset();
    for (int n = 0; n < 48; n++) begin
      rop = 1'($urandom_range(0, 1));
      ra = 8'($urandom); rb = 8'($urandom); rc = 8'($urandom); rd = 8'($urandom);
      if (n % 8 == 3) rb = 8'h00;
      if (!rop) begin
        expv = 16'(int'(ra) * int'(rb) + int'(rc) + int'(rd));
        exp_err = 1'b0;
      end else if (rb == 8'h00) begin
        expv = {8'hFF, ra};
        exp_err = 1'b1;
      end else begin
        expv = {ra / rb, ra % rb};
        exp_err = 1'b0;
      end
      set_req0(rop, ra, rb, rc, rd);
      req0_valid = 1'b1;
      #1;
      for (int w = 0; w < 8 && !req0_ready; w++) tick();
      check("rnd_ready", {15'd0, req0_ready}, 16'd1);
      tick();
      req0_valid = 1'b0;
      for (int w = 0; w < 8 && !rsp0_valid; w++) tick();
      check("rnd_data", {rsp0_hi, rsp0_lo}, expv);
      check("rnd_err", {15'd0, rsp0_err}, {15'd0, exp_err});
      rsp0_ready = 1'b1; tick(); rsp0_ready = 1'b0;
      for (int w = 0; w < 8 && x_busy; w++) tick();
      if (x_rsp0_valid) begin
        rsp0_ready = 1'b1; tick(); rsp0_ready = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/calc_scheduler.md
CALC_SCHEDULER -- requirements
Module: calc_scheduler

Interface
REQ-001 Parameter EXEC_CYCLES, default 1, meaning cycles operands are held on the arithmetic units before capture (legal range 1-15).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 reqN_valid  input  1  requester N (N=0,1) has an operation pending.
REQ-005 reqN_ready  output  1  scheduler accepts requester N this cycle.
REQ-006 reqN_op  input  1  0 = multiply, 1 = divide.
REQ-007 reqN_a, reqN_b  input  8 each  operands (dividend/divisor for divide).
REQ-008 reqN_c, reqN_d  input  8 each  multiply carry-in addends; ignored for divide.
REQ-009 rspN_valid  output  1  result for requester N held.
REQ-010 rspN_ready  input  1  requester N consumes the result.
REQ-011 rspN_hi, rspN_lo  output  8 each  result high/low bytes.
REQ-012 rspN_err  output  1  divide-by-zero flag.
REQ-013 busy  output  1  operation in flight.

Function
REQ-014 The block SHALL contain exactly one multiplier_8 and one divider_8 instance, shared by both requesters.
REQ-015 FSM states SHALL be IDLE and EXEC; busy = (state == EXEC).
REQ-016 Requester N SHALL be eligible when reqN_valid=1 and its response buffer is empty (rspN_valid=0 at the start of the cycle).
REQ-017 In IDLE, grant SHALL go to the single eligible requester; with both eligible, to the one not granted most recently (round-robin pointer).
REQ-018 reqN_ready SHALL be combinational: 1 only in IDLE for the granted requester, 0 otherwise.
REQ-019 On the edge with reqN_valid && reqN_ready: latch op, a, b, c, d and requester id; update pointer; enter EXEC; load counter with EXEC_CYCLES-1.
REQ-020 In EXEC, latched operands SHALL drive the shared units; the counter SHALL decrement each cycle.
REQ-021 On the edge where EXEC counter is 0: capture result into the granted requester's buffer, set rspN_valid=1, return to IDLE.
REQ-022 Latency: accept at edge k -> rspN_valid=1 after edge k+EXEC_CYCLES; next accept no earlier than edge k+EXEC_CYCLES+1.
REQ-023 Multiply: {hi,lo} = a*b + c + d as exact 16-bit value (max 0xFFFF, no overflow); err=0.
REQ-024 Divide, b != 0: hi = a / b, lo = a % b (unsigned); err=0.
REQ-025 Divide, b == 0: hi=0xFF, lo=a, err=1; divider outputs ignored.
REQ-026 rspN_valid && rspN_ready at an edge SHALL clear rspN_valid; hi/lo/err hold their last value.
REQ-027 A buffer draining this cycle SHALL not make its requester eligible until the following cycle.
REQ-028 A response buffer SHALL never be overwritten while rspN_valid=1.
REQ-029 Requests and responses of different requesters are independent: a stalled rspN_ready SHALL not block the other requester.
REQ-030 reqN operand changes while reqN_ready=0 SHALL have no effect.

Reset
REQ-031 rst=1 at an edge SHALL force: state IDLE, counter 0, pointer favouring req0, rsp0_valid=rsp1_valid=0, all rsp hi/lo/err=0, busy=0.
REQ-032 Reset during EXEC SHALL discard the in-flight operation; no response is produced.
REQ-033 reqN_ready SHALL be 0 while rst=1.

Verification
REQ-034 Multiply corner: req0 op=0 a=b=c=d=0xFF, EXEC_CYCLES=1 -> rsp0 hi=0xFF lo=0xFF err=0 after edge k+1.
REQ-035 Divide: req1 op=1 a=200 b=7 -> rsp1 hi=28 lo=4 err=0.
REQ-036 Divide by zero: req0 op=1 a=0x5A b=0 -> rsp0 hi=0xFF lo=0x5A err=1.
REQ-037 Arbitration: both valid from reset with rsp_ready=1 -> grants req0, req1, req0, req1 alternately; no cycle has both ready.
REQ-038 Backpressure: rsp0_ready=0 with rsp0 full, req0 and req1 valid -> req0_ready stays 0, req1 served each EXEC_CYCLES+1 cycles; rsp0 data stable.
REQ-039 Random: 1024 random operand/op sets, EXEC_CYCLES in {1,3}, reset pulsed mid-EXEC -> every response matches REQ-023..025 model; none issued for the reset-aborted operation.
